mem_cycle_ctrl: RTL and testbench
=================================

Name: mem_cycle_ctrl

Overview:
- Bus-cycle sequencer for the memory data register and the memory address path of the processor.
- Accepts read/write requests from two requesters (CPU control unit, debug port) and arbitrates between them round-robin.
- Drives the MDR load/select strobes, memory address and strobes; waits on a memory ready handshake.
- Returns a one-cycle done, plus an error when the optional timeout is compiled in.

Parameters:
- DATA_WIDTH, 8, data bus width; carried for package consistency.
- ADDR_WIDTH, 8, memory address width.
- TIMEOUT_CYCLES, 15, maximum ACCESS cycles without mem_ready. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  CPU request; held until cpu_done.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_done  out  1  one-cycle completion pulse to the CPU.
- dbg_req  in  1  debug request; held until dbg_done.
- dbg_we  in  1  debug write/read.
- dbg_addr  in  ADDR_WIDTH  debug address.
- dbg_done  out  1  one-cycle completion pulse to debug.
- mem_addr  out  ADDR_WIDTH  latched transaction address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_ready  in  1  memory ready (read data valid / write accepted).
- mdr_en  out  1  MDR load strobe (loads both write and read registers).
- mdr_alu_n  out  1  busC select: 1 = MDR read data, 0 = ALU.
- bus_oe  out  1  drive MDR write register onto the data bus.
- busy  out  1  transaction in progress.
- err  out  1  sticky-per-transaction timeout flag, valid with done.

Behaviour:
- Reset (rst_n = 0 at an edge), from any state including mid-transaction:
  - state goes to IDLE.
  - All outputs go to 0, including mem_addr.
  - Round-robin pointer goes to CPU priority.
  - An in-flight transaction is abandoned: no done is issued and no MDR load occurs.
- IDLE:
  - Samples cpu_req and dbg_req.
  - Only one requesting: that requester wins.
  - Both requesting: the pointer's side wins, then the pointer flips to the other side.
  - The winner's addr/we/owner are latched into internal registers, busy goes to 1, and the FSM moves to SETUP.
  - Requests are ignored in every other state.
- SETUP (1 cycle):
  - mem_addr is valid.
  - Write: mdr_en = 1, capturing busALU as write data.
  - Read: no strobes.
  - Next state: ACCESS.
- ACCESS:
  - mem_rd = ~we and mem_wr = we for the whole state.
  - bus_oe = we.
  - On mem_ready = 1 and a read: mdr_en = 1 in that same cycle, so data_bus_in is captured at that edge.
  - On mem_ready = 1 (read or write): next state is DONE.
- DONE (1 cycle):
  - The owner's done = 1 and the other requester's done = 0.
  - mdr_alu_n = 1 for a read, else 0.
  - mem_rd, mem_wr and bus_oe = 0.
  - Next state: IDLE; busy drops on entry to IDLE.
- Latency with mem_ready already high: request sampled at edge 0 (IDLE→SETUP); SETUP→ACCESS at edge 1; ACCESS→DONE at edge 2. done is therefore high in the cycle after edge 2. Each wait cycle adds one cycle.
- Request back-to-back: a requester still asserting in IDLE after its done starts a new transaction. The arbitration pointer prevents starvation.
- mdr_alu_n = 0 and mdr_en = 0 in every state not listed above.
- Address and we changes by a requester after grant have no effect.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A 4+-bit counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to DONE with err = 1 for that DONE cycle.
  - On a timed-out read, the MDR is not loaded.
  - mem_ready arriving in the same cycle as the limit wins: normal completion, err = 0.
- MEM_TIMEOUT_EN undefined:
  - ACCESS waits indefinitely and err is tied to 0.
  - No counter logic is present.

Decomposition:
- Package pdua_mem_pkg:
  - state enum: IDLE, SETUP, ACCESS, DONE.
  - owner encoding: OWN_CPU = 0, OWN_DBG = 1.
  - default timeout constant.
- Sub-module rr_arbiter2:
  - Two-input round-robin arbiter with grant-enable input and pointer register.
  - Reset to CPU priority.

Test Plan:
- CPU read of addr 0x3C with mem_ready tied 1 → mem_rd high one cycle, mdr_en high the same cycle, cpu_done at the 3rd cycle after request, mdr_alu_n = 1 during done, err = 0.
- CPU write of addr 0x81 with mem_ready after 3 wait cycles → mdr_en in SETUP only, mem_wr and bus_oe high 4 cycles, cpu_done 6 cycles after the request.
- cpu_req and dbg_req both asserted in the same cycle after reset, held → grant order CPU, DBG, CPU, DBG; dbg_done never missing.
- rst_n low for 1 cycle during ACCESS of a read → next cycle all outputs 0, no done, no mdr_en; a fresh request then completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 15, mem_ready never set → DONE after 15 ACCESS cycles with err = 1, no mdr_en for the read. Repeat with mem_ready arriving on cycle 15 → err = 0.
- Debug read of 0xFF while CPU is mid-write → debug waits, and is granted in the IDLE cycle after cpu_done.

Source files
------------

// File: rtl/pdua_mem_pkg.sv
// pdua_mem_pkg: shared state, owner and default constants for the memory cycle controller
package pdua_mem_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SETUP = 2'd1;
  localparam state_t ACCESS = 2'd2;
  localparam state_t DONE = 2'd3;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; pointer side wins on contention, then yields
module rr_arbiter2 import pdua_mem_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic any,
  output logic win
);
  logic ptr;
  assign any = cpu_req | dbg_req;
  assign win = (cpu_req & dbg_req) ? ptr : (dbg_req ? OWN_DBG : OWN_CPU);
  always_ff @(posedge clk)
    if (!rst_n) ptr <= OWN_CPU;
    else if (en && cpu_req && dbg_req) ptr <= ~ptr;
endmodule

// File: rtl/mem_cycle_ctrl.sv
// mem_cycle_ctrl: arbitrated MDR/memory bus-cycle sequencer; define MEM_TIMEOUT_EN to bound ACCESS and report err
module mem_cycle_ctrl import pdua_mem_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_done,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic                  mem_ready,
  output logic                  mdr_en,
  output logic                  mdr_alu_n,
  output logic                  bus_oe,
  output logic                  busy,
  output logic                  err
);
  localparam int unused_cfg = DATA_WIDTH + TIMEOUT_CYCLES;
  state_t state, nxt;
  logic own, we_q, any, win, tmo;
  rr_arbiter2 u_arb (
    .clk(clk), .rst_n(rst_n), .en(state == IDLE),
    .cpu_req(cpu_req), .dbg_req(dbg_req), .any(any), .win(win)
  );
`ifdef MEM_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES < 16 ? 4 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic err_q;
  // count holds k-1 in the k-th ACCESS cycle, so the limit trips on the TIMEOUT_CYCLES-th one
  assign tmo = state == ACCESS && !mem_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= state == ACCESS ? cnt + 1'b1 : '0;
      err_q <= tmo;
    end
  assign err = state == DONE && err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_comb
    nxt = state == IDLE   ? (any ? SETUP : IDLE)
        : state == SETUP  ? ACCESS
        : state == ACCESS ? ((mem_ready || tmo) ? DONE : ACCESS)
        : IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      own <= OWN_CPU;
      we_q <= 1'b0;
      mem_addr <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        own <= win;
        we_q <= win ? dbg_we : cpu_we;
        mem_addr <= win ? dbg_addr : cpu_addr;
      end
    end
  assign busy = state != IDLE;
  assign mem_rd = state == ACCESS && !we_q;
  assign mem_wr = state == ACCESS && we_q;
  assign bus_oe = state == ACCESS && we_q;
  // an abandoned read must not load the MDR even if ready lands in the reset cycle
  assign mdr_en = rst_n && ((state == SETUP && we_q) || (state == ACCESS && !we_q && mem_ready));
  assign mdr_alu_n = state == DONE && !we_q;
  assign cpu_done = state == DONE && own == OWN_CPU;
  assign dbg_done = state == DONE && own == OWN_DBG;
endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// tb_mem_cycle_ctrl: directed self-checking bench for mem_cycle_ctrl
module tb_mem_cycle_ctrl;
  logic clk = 1'b0, rst_n, cpu_req, cpu_we, dbg_req, dbg_we, mem_ready;
  logic [7:0] cpu_addr, dbg_addr, mem_addr;
  logic cpu_done, dbg_done, mem_rd, mem_wr, mdr_en, mdr_alu_n, bus_oe, busy, err;
  logic [8:0] outs;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mem_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_done(dbg_done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
    .mdr_en(mdr_en), .mdr_alu_n(mdr_alu_n), .bus_oe(bus_oe), .busy(busy), .err(err)
  );
  assign outs = {cpu_done, dbg_done, mem_rd, mem_wr, mdr_en, mdr_alu_n, bus_oe, busy, err};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input string tag, input logic [8:0] exp);
    #1;
    chk(tag, 32'(outs), 32'(exp));
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; mem_ready = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_addr", 32'(mem_addr), 32'h0);
    cyc("rst_outs", 9'b0);
    rst_n = 1;
    // CPU read, ready tied high
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h3C; mem_ready = 1;
    cyc("rd_idle", 9'b0);
    chk("rd_addr", 32'(mem_addr), 32'h3C);
    cyc("rd_setup", 9'b000000010);
    cyc("rd_access", 9'b001010010);
    cpu_req = 0;
    cyc("rd_done", 9'b100001010);
    cyc("rd_idle2", 9'b0);
    // CPU write, three wait cycles; request fields change after grant
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h81; mem_ready = 0;
    cyc("wr_idle", 9'b0);
    chk("wr_addr", 32'(mem_addr), 32'h81);
    cyc("wr_setup", 9'b000010010);
    cpu_addr = 8'h00; cpu_we = 0;
    for (int i = 0; i < 3; i++) cyc("wr_wait", 9'b000100110);
    mem_ready = 1;
    cyc("wr_ready", 9'b000100110);
    cpu_req = 0;
    chk("wr_addr_hold", 32'(mem_addr), 32'h81);
    cyc("wr_done", 9'b100000010);
    cyc("wr_idle2", 9'b0);
    // simultaneous held requests from reset alternate CPU, DBG, CPU, DBG
    rst_n = 0; @(posedge clk); #1; rst_n = 1;
    cpu_req = 1; cpu_addr = 8'h10; dbg_req = 1; dbg_addr = 8'h20; dbg_we = 0; mem_ready = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("rr_done", 32'({cpu_done, dbg_done}), 32'(i % 8 == 3 ? 2'b10 : i % 8 == 7 ? 2'b01 : 2'b00));
      if (i % 4 == 1) chk("rr_addr", 32'(mem_addr), i % 8 == 1 ? 32'h10 : 32'h20);
      @(posedge clk); #1;
    end
    cpu_req = 0; dbg_req = 0;
    cyc("rr_idle", 9'b0);
    // reset during a read ACCESS abandons it
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h55; mem_ready = 0;
    cyc("rs_idle", 9'b0);
    cyc("rs_setup", 9'b000000010);
    cyc("rs_access", 9'b001000010);
    rst_n = 0; mem_ready = 1; cpu_req = 0;
    #1;
    chk("rs_mdr_en", 32'(mdr_en), 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    chk("rs_addr", 32'(mem_addr), 32'h0);
    cyc("rs_after", 9'b0);
    cyc("rs_quiet", 9'b0);
    cpu_req = 1; cpu_addr = 8'h3C;
    cyc("rs2_idle", 9'b0);
    cyc("rs2_setup", 9'b000000010);
    cyc("rs2_access", 9'b001010010);
    cpu_req = 0;
    cyc("rs2_done", 9'b100001010);
    cyc("rs2_idle2", 9'b0);
    // debug read arrives mid CPU write and waits for the next IDLE
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h81; mem_ready = 1;
    cyc("dw_idle", 9'b0);
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'hFF;
    cyc("dw_setup", 9'b000010010);
    cyc("dw_access", 9'b000100110);
    cpu_req = 0;
    cyc("dw_cpu_done", 9'b100000010);
    cyc("dw_grant", 9'b0);
    chk("dw_addr", 32'(mem_addr), 32'hFF);
    cyc("dw_dsetup", 9'b000000010);
    cyc("dw_daccess", 9'b001010010);
    dbg_req = 0;
    cyc("dw_dbg_done", 9'b010001010);
    cyc("dw_idle2", 9'b0);
`ifdef MEM_TIMEOUT_EN
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h0A; mem_ready = 0;
    cyc("to_idle", 9'b0);
    cyc("to_setup", 9'b000000010);
    for (int i = 0; i < 15; i++) cyc("to_wait", 9'b001000010);
    cpu_req = 0;
    cyc("to_done", 9'b100001011);
    cyc("to_idle2", 9'b0);
    cpu_req = 1;
    cyc("tr_idle", 9'b0);
    cyc("tr_setup", 9'b000000010);
    for (int i = 0; i < 14; i++) cyc("tr_wait", 9'b001000010);
    mem_ready = 1;
    cyc("tr_last", 9'b001010010);
    cpu_req = 0;
    cyc("tr_done", 9'b100001010);
    cyc("tr_idle2", 9'b0);
`else
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h0A; mem_ready = 0;
    cyc("nt_idle", 9'b0);
    cyc("nt_setup", 9'b000000010);
    for (int i = 0; i < 20; i++) cyc("nt_wait", 9'b001000010);
    mem_ready = 1;
    cyc("nt_ready", 9'b001010010);
    cpu_req = 0;
    cyc("nt_done", 9'b100001010);
    cyc("nt_idle2", 9'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
